shared_mem_port: RTL and testbench
==================================

# shared_mem_port

- Single-port front end to the shared memory, directly downstream of the 3-CPU grant arbiter.
- Consumes the arbiter's 2-bit `grant` code and latches the owning CPU's address, write data and direction.
- Runs one memory transaction at a time with a ready handshake and a timeout, then returns a one-cycle ack (or error) and read data to the owning CPU.

## Interface
Parameters:
- `ADDR_W`, 8: address width.
- `DATA_W`, 16: data width.
- `TIMEOUT`, 15: maximum WAIT cycles before abort; legal range 1..255.

Ports:
- `clk`  input  1  single clock; all flops rise on posedge.
- `reset`  input  1  asynchronous, active-high reset.
- `grant`  input  2  owner code from arbiter: 00 none, 01 CPU1, 10 CPU2, 11 CPU3.
- `req1`/`req2`/`req3`  input  1 each  CPU access request, held until ack/err.
- `addr1`/`addr2`/`addr3`  input  ADDR_W each  CPU address.
- `wdata1`/`wdata2`/`wdata3`  input  DATA_W each  CPU write data.
- `we1`/`we2`/`we3`  input  1 each  1 = write, 0 = read.
- `ack1`/`ack2`/`ack3`  output  1 each  one-cycle completion pulse to owner.
- `err`  output  1  one-cycle pulse, coincident with the owner's ack, when the access timed out.
- `rdata`  output  DATA_W  read data, broadcast; valid only in the ack cycle of a read.
- `busy`  output  1  high in every state except IDLE.
- `mem_en`  output  1  memory strobe, exactly one cycle per transaction.
- `mem_we`  output  1  registered direction.
- `mem_addr`  output  ADDR_W  registered address.
- `mem_wdata`  output  DATA_W  registered write data.
- `mem_rdata`  input  DATA_W  memory read data, valid when `mem_rdy` = 1.
- `mem_rdy`  input  1  memory completion, single-cycle pulse.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE (2-bit encoding).
- **IDLE:** accept when `grant` != 00 and the matching `req` is high.
  - Latch `owner` = `grant`, plus that CPU's addr, wdata and we, into the `mem_*` registers.
  - Go to ISSUE.
  - If `grant` = 00, or the matching `req` is low, stay in IDLE and issue nothing.
- **ISSUE:** `mem_en` = 1 for this cycle only; clear the timeout counter; go to WAIT.
- **WAIT:**
  - If `mem_rdy` = 1: capture `mem_rdata` into `rdata` (reads only; `rdata` holds on writes), clear the error flag, go to DONE.
  - Else, if the counter reaches TIMEOUT: set the error flag and go to DONE.
  - Else: increment the counter.
  - Counter width is 8 bits; it never wraps, because TIMEOUT ≤ 255.
- **DONE:** pulse `ack` for `owner` only; pulse `err` too if the error flag is set; go to IDLE.
- `mem_rdy` outside WAIT (stray, or in the ISSUE cycle) is ignored and has no effect.
- **Latched owner:** once accepted, the transaction completes to the latched owner.
  - `grant` changes during ISSUE/WAIT/DONE are ignored.
  - Dropping `req` mid-transaction does not abort; the ack still pulses.
- **Reset:** async `reset` forces IDLE immediately, from any state including mid-WAIT, and drops the transaction silently (no ack).
- **Output reset values:** all outputs 0 (`ack*`, `err`, `busy`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`).
  - `owner` and the counter also reset to 0.
- **Output drive:** all outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Timing
- **Accept edge (edge 0):** in IDLE, `grant`/`req` sampled high.
- **Cycle after edge 0:** ISSUE; `mem_en` = 1 and `mem_addr`/`mem_we`/`mem_wdata` are valid, and they hold stable until the next accept.
- **Edge 1:** WAIT is entered.
- **Completion:** `mem_rdy` high at the k-th WAIT edge (k ≥ 1) puts `ack` and `rdata` in the following cycle.
  - Minimum latency, accept edge to ack cycle: 3 cycles.
- **Timeout:** with no `mem_rdy`, `ack` + `err` assert after TIMEOUT+1 WAIT cycles.
- **Back-to-back:** after DONE, IDLE lasts at least one cycle before the next accept. Minimum transaction period is 4 cycles.
- **`busy`:** rises in the cycle after accept and falls in the cycle after DONE.

## Test plan
- **CPU1 read:** grant=01, req1=1, we1=0, addr1=0x3C, memory returns 0xBEEF with `mem_rdy` at the 2nd WAIT edge.
  - Expect one `mem_en` cycle with mem_addr=0x3C and mem_we=0.
  - Expect ack1 for one cycle with rdata=0xBEEF, err=0, and ack2/ack3 low throughout.
- **CPU3 write:** grant=11, we3=1, addr3=0x05, wdata3=0x1234, `mem_rdy` at the 1st WAIT edge.
  - Expect mem_we=1, mem_wdata=0x1234, and ack3 exactly 3 cycles after accept.
  - Expect rdata unchanged from its prior value.
- **Grant switch mid-WAIT:** grant switches 10→01 during WAIT of a CPU2 read.
  - Expect only ack2; no second `mem_en` until after DONE plus one IDLE cycle.
  - Then the CPU1 transaction is accepted.
- **Timeout:** TIMEOUT=15, `mem_rdy` never asserted on a CPU2 read.
  - Expect ack2 and err high together 16 WAIT cycles after entering WAIT, then IDLE.
  - A stray `mem_rdy` afterwards produces no ack.
- **Reset mid-WAIT:** assert `reset` asynchronously mid-WAIT, not aligned to `clk`.
  - Expect busy, mem_en and all ack outputs low immediately, and no ack after release.
  - Next request proceeds normally.
- **No-accept cases:**
  - grant=01 with req1=0 (req2=1): stays IDLE, mem_en never asserts.
  - grant=00 with all req high: no accept.

Source files
------------

// File: rtl/shared_mem_port.sv
// Single-port shared-memory front end: latches the granted CPU's request, runs one
// memory transaction with a ready handshake and timeout, and acks the latched owner.
module shared_mem_port #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        grant,
   input  logic              req1,
   input  logic              req2,
   input  logic              req3,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [ADDR_W-1:0] addr3,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   input  logic [DATA_W-1:0] wdata3,
   input  logic              we1,
   input  logic              we2,
   input  logic              we3,
   output logic              ack1,
   output logic              ack2,
   output logic              ack3,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t              state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                err_flag_q, err_flag_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                sel_req;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   // Request fields of whichever CPU the arbiter currently names.
   always_comb begin
      sel_req   = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      case (grant)
         2'd1: begin sel_req = req1; sel_we = we1; sel_addr = addr1; sel_wdata = wdata1; end
         2'd2: begin sel_req = req2; sel_we = we2; sel_addr = addr2; sel_wdata = wdata2; end
         2'd3: begin sel_req = req3; sel_we = we3; sel_addr = addr3; sel_wdata = wdata3; end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      err_flag_d  = err_flag_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'd0 && sel_req) begin
               owner_d     = grant;
               mem_we_d    = sel_we;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_rdy) begin
               if (!mem_we_q) rdata_d = mem_rdata;
               err_flag_d = 1'b0;
               state_d    = DONE;
            end else if (cnt_q == TIMEOUT_C) begin
               err_flag_d = 1'b1;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 2'd0;
         cnt_q       <= 8'd0;
         err_flag_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         err_flag_q  <= err_flag_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   // Strobes are decoded from registered state only, so reset clears them at once.
   assign busy      = (state_q != IDLE);
   assign mem_en    = (state_q == ISSUE);
   assign ack1      = (state_q == DONE) && (owner_q == 2'd1);
   assign ack2      = (state_q == DONE) && (owner_q == 2'd2);
   assign ack3      = (state_q == DONE) && (owner_q == 2'd3);
   assign err       = (state_q == DONE) && err_flag_q;
   assign rdata     = rdata_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_shared_mem_port.sv
// Self-checking bench for shared_mem_port: directed scenarios plus randomized
// transactions checked against a per-transaction timing model.
module tb_shared_mem_port;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  grant;
   logic        req1, req2, req3;
   logic [7:0]  addr1, addr2, addr3;
   logic [15:0] wdata1, wdata2, wdata3;
   logic        we1, we2, we3;
   logic        ack1, ack2, ack3, err, busy, mem_en, mem_we;
   logic [15:0] rdata, mem_wdata, mem_rdata;
   logic [7:0]  mem_addr;
   logic        mem_rdy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_rdata = 16'h0;

   shared_mem_port #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .grant(grant),
      .req1(req1), .req2(req2), .req3(req3),
      .addr1(addr1), .addr2(addr2), .addr3(addr3),
      .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
      .we1(we1), .we2(we2), .we3(we3),
      .ack1(ack1), .ack2(ack2), .ack3(ack3), .err(err),
      .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_cpus(input logic [1:0] own, input logic [7:0] a,
                             input logic [15:0] wd, input logic w);
      addr1 = 8'($urandom); addr2 = 8'($urandom); addr3 = 8'($urandom);
      wdata1 = 16'($urandom); wdata2 = 16'($urandom); wdata3 = 16'($urandom);
      we1 = 1'($urandom); we2 = 1'($urandom); we3 = 1'($urandom);
      req1 = 1'($urandom); req2 = 1'($urandom); req3 = 1'($urandom);
      case (own)
         2'd1: begin addr1 = a; wdata1 = wd; we1 = w; req1 = 1'b1; end
         2'd2: begin addr2 = a; wdata2 = wd; we2 = w; req2 = 1'b1; end
         2'd3: begin addr3 = a; wdata3 = wd; we3 = w; req3 = 1'b1; end
         default: ;
      endcase
      grant = own;
   endtask

   task automatic set_req(input logic [1:0] who, input logic v);
      case (who)
         2'd1: req1 = v;
         2'd2: req2 = v;
         2'd3: req3 = v;
         default: ;
      endcase
   endtask

   // Called just after a negedge. mem_rdy arrives at the k-th WAIT edge; k > TO+1 means never.
   task automatic run_txn(input logic [1:0] own, input logic [7:0] a, input logic [15:0] wd,
                          input logic w, input int k, input logic drop_req,
                          input logic [1:0] mid_grant, input logic stray);
      int          ack_n;
      logic        timed;
      logic [15:0] cap;
      logic [15:0] rd_exp;
      logic [5:0]  exp_v, got_v;
      timed = (k > TO + 1);
      ack_n = timed ? TO + 3 : k + 2;
      cap   = 16'h0;
      drive_cpus(own, a, wd, w);
      mem_rdy = 1'b0;
      @(posedge clk);
      for (int n = 1; n <= ack_n + 1; n++) begin
         @(negedge clk);
         exp_v = {n <= ack_n, n == 1, (n == ack_n) && (own == 2'd1),
                  (n == ack_n) && (own == 2'd2), (n == ack_n) && (own == 2'd3),
                  (n == ack_n) && timed};
         got_v = {busy, mem_en, ack1, ack2, ack3, err};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL txn_ctrl cycle %0d own=%0d {busy,en,ack1,ack2,ack3,err}: got %b, required %b",
                     n, own, got_v, exp_v);
         end
         if (n == 1 || n == ack_n + 1) begin
            n_checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {w, a, wd}) begin
               n_fail++;
               $display("FAIL mem_regs cycle %0d: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                        n, mem_we, mem_addr, mem_wdata, w, a, wd);
            end
         end
         if (n == ack_n) begin
            rd_exp = (!w && !timed) ? cap : exp_rdata;
            n_checks++;
            if (rdata !== rd_exp) begin
               n_fail++;
               $display("FAIL rdata own=%0d we=%0b timed=%0b: got %h, required %h", own, w, timed, rdata, rd_exp);
            end
            exp_rdata = rd_exp;
         end
         mem_rdy   = (n == k + 1) || (stray && n == 1);
         mem_rdata = 16'($urandom);
         if (n == k + 1) cap = mem_rdata;
         if (n == 1) begin
            if (drop_req) set_req(own, 1'b0);
            if (mid_grant != 2'd0) begin
               grant = mid_grant;
               set_req(mid_grant, 1'b1);
            end
         end
         if (n == ack_n + 1) begin
            grant = 2'd0; req1 = 1'b0; req2 = 1'b0; req3 = 1'b0; mem_rdy = 1'b0;
         end
      end
      $display("txn own=%0d we=%0b addr=%h k=%0d timeout=%0b rdata=%h", own, w, a, k, timed, rdata);
   endtask

   task automatic test_reset();
      reset = 1'b1; grant = 2'd0; req1 = 0; req2 = 0; req3 = 0;
      addr1 = 0; addr2 = 0; addr3 = 0; wdata1 = 0; wdata2 = 0; wdata3 = 0;
      we1 = 0; we2 = 0; we3 = 0; mem_rdy = 0; mem_rdata = 0;
      #1;
      n_checks++;
      if ({busy, mem_en, ack1, ack2, ack3, err, mem_we, mem_addr, mem_wdata, rdata} !== 46'h0) begin
         n_fail++;
         $display("FAIL reset_values: got busy=%0b en=%0b acks=%0b%0b%0b err=%0b we=%0b addr=%h wd=%h rd=%h, required all 0",
                  busy, mem_en, ack1, ack2, ack3, err, mem_we, mem_addr, mem_wdata, rdata);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, mem_en} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%0b en=%0b, required 0 0", busy, mem_en);
      end
   endtask

   task automatic test_cpu1_read();
      run_txn(2'd1, 8'h3C, 16'h0000, 1'b0, 2, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_cpu3_write();
      run_txn(2'd3, 8'h05, 16'h1234, 1'b1, 1, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_grant_switch();
      run_txn(2'd2, 8'h77, 16'h5555, 1'b0, 4, 1'b0, 2'd1, 1'b0);
      run_txn(2'd1, 8'h12, 16'hA5A5, 1'b0, 1, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_timeout();
      run_txn(2'd2, 8'h40, 16'h0F0F, 1'b0, 1000, 1'b0, 2'd0, 1'b0);
      mem_rdy = 1'b1;
      @(negedge clk);
      mem_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, ack1, ack2, ack3, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL stray_rdy cycle %0d {busy,ack1,ack2,ack3,err}: got %b, required 00000",
                     i, {busy, ack1, ack2, ack3, err});
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      drive_cpus(2'd2, 8'h99, 16'h1111, 1'b0);
      mem_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, mem_en, ack1, ack2, ack3, err} !== 6'b0 || rdata !== 16'h0 || mem_addr !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: got ctrl=%b rdata=%h addr=%h, required 000000 0000 00",
                  {busy, mem_en, ack1, ack2, ack3, err}, rdata, mem_addr);
      end
      exp_rdata = 16'h0;
      grant = 2'd0; req1 = 0; req2 = 0; req3 = 0;
      #4 reset = 1'b0;
      @(negedge clk);
      mem_rdy = 1'b1;
      @(negedge clk);
      mem_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, ack1, ack2, ack3, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle cycle %0d: got %b, required 00000", i, {busy, ack1, ack2, ack3, err});
         end
      end
      run_txn(2'd2, 8'h9A, 16'h2222, 1'b0, 3, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_no_accept();
      grant = 2'd1; req1 = 1'b0; req2 = 1'b1; req3 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            grant = 2'd0; req1 = 1'b1;
         end
         @(negedge clk);
         n_checks++;
         if ({busy, mem_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL no_accept cycle %0d grant=%0d: got busy=%0b en=%0b, required 0 0", i, grant, busy, mem_en);
         end
      end
      grant = 2'd0; req1 = 0; req2 = 0; req3 = 0;
   endtask

   task automatic test_random();
      for (int t = 0; t < 30; t++) begin
         run_txn(2'($urandom_range(1, 3)), 8'($urandom), 16'($urandom), 1'($urandom),
                 int'($urandom_range(1, 20)), 1'($urandom), 2'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_cpu1_read();
      test_cpu3_write();
      test_grant_switch();
      test_timeout();
      test_reset_mid_wait();
      test_no_accept();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
